// File: rtl/mem_stage.sv
// Memory-access stage: splits loads/stores into byte transactions on a shared byte-wide RAM port.
// Latency: non-memory ops 0 cycles; load N+1 cycles, store N cycles (gnt held); stallreq holds ex_mem meanwhile.
// Optional MEM_ALIGN_CHECK_EN: misaligned LH/LHU/SH/LW/SW retire as NOPs and raise err_misalign.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  mem_opcode,
    input  logic [7:0]  mem_opt,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_rdata2,
    input  logic        ram_gnt,
    input  logic [7:0]  ram_rdata,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        stallreq,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        err_misalign
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] OPT_LB  = 8'd10, OPT_LH  = 8'd11, OPT_LW = 8'd12;
    localparam logic [7:0] OPT_LBU = 8'd13, OPT_LHU = 8'd14;
    localparam logic [7:0] OPT_SB  = 8'd15, OPT_SH  = 8'd16, OPT_SW = 8'd17;

    logic [2:0]  cnt;
    logic        pend;
    logic [31:0] buf_q;

    logic        is_load, is_store, sext, misalign, active;
    logic [2:0]  nbytes;
    logic        issue, granted, load_done, store_done;
    logic [1:0]  cap_idx;
    logic [31:0] merged, load_word;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        nbytes   = 3'd0;
        if (mem_opcode == OP_LOAD) begin
            case (mem_opt)
                OPT_LB:  begin is_load = 1'b1; nbytes = 3'd1; sext = 1'b1; end
                OPT_LH:  begin is_load = 1'b1; nbytes = 3'd2; sext = 1'b1; end
                OPT_LW:  begin is_load = 1'b1; nbytes = 3'd4; end
                OPT_LBU: begin is_load = 1'b1; nbytes = 3'd1; end
                OPT_LHU: begin is_load = 1'b1; nbytes = 3'd2; end
                default: ;
            endcase
        end else if (mem_opcode == OP_STORE) begin
            case (mem_opt)
                OPT_SB:  begin is_store = 1'b1; nbytes = 3'd1; end
                OPT_SH:  begin is_store = 1'b1; nbytes = 3'd2; end
                OPT_SW:  begin is_store = 1'b1; nbytes = 3'd4; end
                default: ;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ((nbytes == 3'd2) && mem_alu[0]) ||
                      ((nbytes == 3'd4) && (mem_alu[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign active     = (is_load || is_store) && !misalign;
    assign issue      = active && (cnt < nbytes);
    assign granted    = issue && ram_gnt;
    assign load_done  = active && is_load && pend && (cnt == nbytes);
    assign store_done = active && is_store && granted && (cnt == nbytes - 3'd1);

    // The byte captured this cycle belongs at lane cnt-1; cnt==4 wraps to lane 3.
    assign cap_idx = cnt[1:0] - 2'd1;

    always_comb begin
        merged = buf_q;
        if (pend) merged[{cap_idx, 3'b000} +: 8] = ram_rdata;
    end

    always_comb begin
        case (nbytes)
            3'd1:    load_word = sext ? {{24{merged[7]}}, merged[7:0]}
                                      : {24'b0, merged[7:0]};
            3'd2:    load_word = sext ? {{16{merged[15]}}, merged[15:0]}
                                      : {16'b0, merged[15:0]};
            default: load_word = merged;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 3'd0;
            pend  <= 1'b0;
            buf_q <= 32'd0;
        end else begin
            pend <= granted && is_load;
            if (load_done || store_done) cnt <= 3'd0;
            else if (granted)            cnt <= cnt + 3'd1;
            if (pend) buf_q[{cap_idx, 3'b000} +: 8] <= ram_rdata;
        end
    end

    always_comb begin
        ram_req      = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = 32'd0;
        ram_wdata    = 8'd0;
        stallreq     = 1'b0;
        wb_we        = 1'b0;
        wb_waddr     = 5'd0;
        wb_wdata     = 32'd0;
        err_misalign = 1'b0;
        if (!rst) begin
            err_misalign = misalign;
            if (!(is_load || is_store)) begin
                wb_we    = mem_we;
                wb_waddr = mem_waddr;
                wb_wdata = mem_alu;
            end else if (!misalign) begin
                ram_req  = issue;
                stallreq = !(load_done || store_done);
                wb_waddr = mem_waddr;
                if (issue) begin
                    ram_we    = is_store;
                    ram_addr  = mem_alu + {29'd0, cnt};
                    ram_wdata = mem_rdata2[{cnt[1:0], 3'b000} +: 8];
                end
                if (load_done) begin
                    wb_we    = mem_we;
                    wb_wdata = load_word;
                end
            end
        end
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It sits between the `ex_mem` pipeline register and the `mem_wb` register, and consumes the register's `mem_*` outputs. Non-memory instructions pass straight through to write-back. Loads and stores are split into byte transactions on the shared byte-wide RAM port, and `stallreq` freezes the front of the pipeline until each access completes.

## Interface
No parameters.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high (`Enable`)
- mem_opcode  in  `OpcodeBus` (7)  opcode from ex_mem
- mem_opt  in  `OptBus`  operation code from ex_mem
- mem_we  in  1  register write enable from ex_mem
- mem_waddr  in  `RegAddrBus` (5)  destination register
- mem_alu  in  `RegBus` (32)  ALU result; effective address for loads and stores
- mem_rdata2  in  `RegBus` (32)  store data (rs2)
- ram_gnt  in  1  arbiter grant; a byte issue happens only in a cycle with ram_req && ram_gnt
- ram_rdata  in  8  read byte, valid the cycle after a granted read
- ram_req  out  1  request for the RAM port
- ram_we  out  1  1 = write byte, 0 = read byte
- ram_addr  out  32  byte address
- ram_wdata  out  8  write byte
- stallreq  out  1  stall request to the stall controller
- wb_we  out  1  write-back enable to mem_wb
- wb_waddr  out  5  write-back register
- wb_wdata  out  32  write-back data
- err_misalign  out  1  misaligned access flag; constant 0 unless `MEM_ALIGN_CHECK_EN` is defined

## Operation
- Memory op:
  - Load: mem_opcode == 7'b0000011. Ops OptLB/LH/LW/LBU/LHU.
  - Store: mem_opcode == 7'b0100011. Ops OptSB/SH/SW.
  - Byte count N = 1, 2 or 4.
- Non-memory op:
  - wb_we = mem_we, wb_waddr = mem_waddr, wb_wdata = mem_alu, combinationally.
  - ram_req = 0, stallreq = 0.
- Registers:
  - cnt (0..4): bytes issued.
  - pend: a read was granted last cycle.
  - buf[31:0]: assembled load data.
- Byte addressing is little-endian: byte k goes to address mem_alu+k, data bits [8k+7:8k].
- Issue:
  - While the op is a memory op and cnt < N: ram_req = 1, ram_addr = mem_alu + cnt, ram_we = store, ram_wdata = mem_rdata2[8cnt+7:8cnt].
  - On a granted issue, cnt increments.
  - pend <= granted && load.
- Load capture: when pend is 1, buf[8(cnt-1)+7 : 8(cnt-1)] <= ram_rdata.
- Load completion cycle: pend && cnt == N.
  - wb_wdata = assembled word, with the final byte taken directly from ram_rdata.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
  - wb_we = mem_we, stallreq = 0.
  - At the clock edge: cnt <= 0, pend <= 0.
- Store completion cycle: granted issue with cnt == N-1.
  - stallreq = 0, wb_we = 0.
  - At the clock edge: cnt <= 0.
- stallreq is 1 in every other cycle in which a memory op is present.
- While stallreq = 1, wb_we is forced to 0.
- Reset:
  - Clears cnt, pend and buf.
  - While rst = 1, every output is 0: ram_req, ram_we, ram_addr, ram_wdata, stallreq, wb_we, wb_waddr, wb_wdata, err_misalign.
  - Reset mid-access abandons the access. The next cycle restarts at byte 0.

## Timing
- Load, ram_gnt held high:
  - Issues in cycles 0..N-1; captures in cycles 1..N.
  - stallreq is high in cycles 0..N-1. Result is in cycle N.
  - Occupancy N+1 cycles.
- Store, ram_gnt held high:
  - Writes in cycles 0..N-1.
  - stallreq is high in cycles 0..N-2 and low in cycle N-1.
  - SB never stalls.
- A cycle with ram_gnt = 0 issues nothing and extends the access by one cycle.
  - Load capture follows grants, not cycles.
  - With ram_req = 1 and ram_gnt = 0, the outputs hold.
- Back-to-back memory ops: ex_mem advances at the completion edge. cnt is already 0, so the next op issues in the following cycle with no idle gap.
- Inputs are held stable by ex_mem (stall[3]) while stallreq = 1. The block does not latch them.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned access: LH/LHU/SH with mem_alu[0] = 1, or LW/SW with mem_alu[1:0] != 0.
  - For such an access: err_misalign = 1 for that cycle, ram_req = 0, stallreq = 0, wb_we = 0.
  - The instruction retires as a NOP.
- `MEM_ALIGN_CHECK_EN` undefined: err_misalign = 0, and misaligned accesses proceed byte-wise normally.

## Test plan
- LW at 0x100, RAM bytes 0x78, 0x56, 0x34, 0x12, gnt = 1, waddr = 5 -> ram_addr 0x100..0x103 in cycles 0-3; stallreq 1 in cycles 0-3; cycle 4: wb_we = 1, wb_waddr = 5, wb_wdata = 0x12345678.
- LB and LBU at 0x40, byte 0x80 -> wb_wdata 0xFFFFFF80 and 0x00000080 respectively, in cycle 1.
- SH at 0x200, rdata2 = 0xAABBCCDD -> cycle 0 writes 0xDD @0x200 with stallreq = 1; cycle 1 writes 0xCC @0x201 with stallreq = 0; wb_we = 0.
- LW with ram_gnt low in cycle 1 only -> byte 1 issued in cycle 2; completes in cycle 5 with the correct word; ram_addr held at 0x101 during cycle 1.
- ADD result 0x7, waddr 3, followed by rst asserted during cycle 2 of an LW -> ADD: wb_wdata = 7 in the same cycle with stallreq 0; after reset: all outputs 0, and the next LW issues 0x100 first.
- With `MEM_ALIGN_CHECK_EN`, LW at 0x102 -> err_misalign = 1, ram_req = 0, stallreq = 0, wb_we = 0.
